// File: rtl/mux_arb_pkg.sv
// Shared definitions for the N-channel stream arbiter: mode encodings, output stage
// states and a wrapped priority search used by the fixed-priority and round-robin modes.
package mux_arb_pkg;

  localparam logic [1:0] MODE_FORCE = 2'b00;
  localparam logic [1:0] MODE_FIXED = 2'b01;
  localparam logic [1:0] MODE_RR    = 2'b10;

  // Upper bound on channel count supported by the search helper.
  localparam int unsigned MaxCh   = 64;
  localparam int unsigned MaxIdxW = $clog2(MaxCh);

  typedef enum logic [0:0] {StEmpty, StFull} out_state_e;

  typedef struct packed {
    logic               found;
    logic [MaxIdxW-1:0] idx;
  } search_t;

  // First set bit of req[n-1:0] searching upward from start, wrapping n-1 -> 0.
  function automatic search_t wrap_search(input logic [MaxCh-1:0] req,
                                          input int unsigned      n,
                                          input int unsigned      start);
    search_t     res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 0; k < MaxCh; k++) begin
      idx = start + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !res.found && req[idx[MaxIdxW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = idx[MaxIdxW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant generation for forced, fixed-priority and round-robin modes; owns the
// round-robin pointer, which advances only on a transfer in round-robin mode.
module rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned NCH  = 4,
  parameter int unsigned SELW = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH-1:0]  in_valid,
  input  logic [1:0]      mode,
  input  logic [SELW-1:0] sel,
  input  logic            advance,
  output logic            grant_valid,
  output logic [SELW-1:0] grant_idx
);

  localparam logic [SELW-1:0] LastCh = SELW'(NCH - 1);

  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [MaxCh-1:0] req;
  search_t          res;

  always_comb begin
    req              = '0;
    req[NCH-1:0]     = in_valid;
    grant_valid      = 1'b0;
    grant_idx        = '0;
    res              = '0;
    if (mode == MODE_FORCE) begin
      // Out-of-range selects never grant, even when NCH is not a power of two.
      if ((32'(sel) < NCH) && req[MaxIdxW'(sel)]) begin
        grant_valid = 1'b1;
        grant_idx   = sel;
      end
    end else begin
      if (mode == MODE_FIXED) res = wrap_search(req, NCH, 0);
      else                    res = wrap_search(req, NCH, 32'(rr_ptr_q));
      grant_valid = res.found;
      grant_idx   = res.idx[SELW-1:0];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance && mode[1]) begin
      rr_ptr_d = (grant_idx == LastCh) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/mux_n_stream_arb.sv
// N-channel valid/ready stream arbiter: picks one input beat per cycle and holds it in a
// one-entry output register that supports back-to-back drain-and-load.
module mux_n_stream_arb
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SELW  = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]     in_valid,
  output logic [NCH-1:0]     in_ready,
  input  logic [1:0]         mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_ch,
  output logic               out_valid,
  input  logic               out_ready
);

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic             load_en, transfer, grant_valid;
  logic [SELW-1:0]  grant_idx;

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .mode        (mode),
    .sel         (sel),
    .advance     (transfer),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    // rst_n gates load_en so no handshake can complete while reset is held.
    load_en  = rst_n & ((state_q == StEmpty) | out_ready);
    transfer = load_en & grant_valid;
    in_ready = '0;
    if (transfer) in_ready[grant_idx] = 1'b1;

    state_d = state_q;
    data_d  = data_q;
    ch_d    = ch_q;
    if (transfer) begin
      state_d = StFull;
      data_d  = in_data[grant_idx*WIDTH +: WIDTH];
      ch_d    = grant_idx;
    end else if (out_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
    end
  end

  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule

// File: tb/tb_mux_n_stream_arb.sv
// Directed bench for mux_n_stream_arb: NCH=4 main instance plus an NCH=3 instance for the
// out-of-range select boundary.
module tb_mux_n_stream_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [1:0]  mode, sel;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid, out_ready;

  logic [23:0] d3_in_data;
  logic [2:0]  d3_in_valid, d3_in_ready;
  logic [1:0]  d3_mode, d3_sel, d3_out_ch;
  logic [7:0]  d3_out_data;
  logic        d3_out_valid;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  mux_n_stream_arb #(.WIDTH(8), .NCH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mux_n_stream_arb #(.WIDTH(8), .NCH(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (d3_in_data),
    .in_valid  (d3_in_valid),
    .in_ready  (d3_in_ready),
    .mode      (d3_mode),
    .sel       (d3_sel),
    .out_data  (d3_out_data),
    .out_ch    (d3_out_ch),
    .out_valid (d3_out_valid),
    .out_ready (1'b1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic [1:0] c);
    chk({tag, ".valid"}, 8'(out_valid), 8'(v));
    chk({tag, ".data"}, out_data, d);
    chk({tag, ".ch"}, 8'(out_ch), 8'(c));
  endtask

  initial begin
    rst_n       = 1'b0;
    in_data     = {8'hA5, 8'h3C, 8'h55, 8'h01};
    in_valid    = 4'hF;
    mode        = 2'b00;
    sel         = 2'd2;
    out_ready   = 1'b0;
    d3_in_data  = {8'h33, 8'h22, 8'h11};
    d3_in_valid = 3'b111;
    d3_mode     = 2'b00;
    d3_sel      = 2'd3;

    tick();
    tick();
    chk_out("reset", 1'b0, 8'h00, 2'd0);
    chk("reset.in_ready", 8'(in_ready), 8'h0);

    // Forced select of channel 2.
    rst_n = 1'b1;
    #1;
    chk("force.in_ready", 8'(in_ready), 8'b0100);
    chk("n3.sel3.in_ready", 8'(d3_in_ready), 8'h0);
    d3_sel = 2'd2;
    #1;
    chk("n3.sel2.in_ready", 8'(d3_in_ready), 8'b100);
    tick();
    chk_out("force.sel2", 1'b1, 8'h3C, 2'd2);

    // Select toggled 0/1/0 with the consumer always ready.
    out_ready = 1'b1;
    sel = 2'd0;
    #1;
    chk("force.sel0.in_ready", 8'(in_ready), 8'b0001);
    tick();
    chk_out("force.sel0", 1'b1, 8'h01, 2'd0);
    sel = 2'd1;
    tick();
    chk_out("force.sel1", 1'b1, 8'h55, 2'd1);
    sel = 2'd0;
    tick();
    chk_out("force.sel0b", 1'b1, 8'h01, 2'd0);

    // Fixed priority: channel 1 wins over 3 every cycle.
    mode = 2'b01;
    in_valid = 4'b1010;
    #1;
    chk("fixed.in_ready", 8'(in_ready), 8'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("fixed.beat", 1'b1, 8'h55, 2'd1);
    end

    // Round-robin from pointer 0, all valid: 0,1,2,3,0.
    mode = 2'b10;
    in_valid = 4'hF;
    tick();
    chk_out("rr.0", 1'b1, 8'h01, 2'd0);
    tick();
    chk_out("rr.1", 1'b1, 8'h55, 2'd1);
    tick();
    chk_out("rr.2", 1'b1, 8'h3C, 2'd2);
    tick();
    chk_out("rr.3", 1'b1, 8'hA5, 2'd3);
    tick();
    chk_out("rr.4", 1'b1, 8'h01, 2'd0);

    // Pointer now 1; only channels 0 and 3 valid (mode 11 also round-robin).
    mode = 2'b11;
    in_valid = 4'b1001;
    tick();
    chk_out("rr.wrap3", 1'b1, 8'hA5, 2'd3);
    tick();
    chk_out("rr.wrap0", 1'b1, 8'h01, 2'd0);

    // Backpressure: held beat stable, no input ready.
    mode = 2'b10;
    in_valid = 4'hF;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.in_ready", 8'(in_ready), 8'h0);
      tick();
      chk_out("bp.hold", 1'b1, 8'h01, 2'd0);
    end

    // Release: pointer still 1, so channel 1 loads with no bubble.
    out_ready = 1'b1;
    #1;
    chk("bp.release.in_ready", 8'(in_ready), 8'b0010);
    tick();
    chk_out("bp.release", 1'b1, 8'h55, 2'd1);

    // Forced select of a non-valid channel: no grant, output drains, data held.
    mode = 2'b00;
    sel = 2'd3;
    in_valid = 4'b0111;
    #1;
    chk("bound.in_ready", 8'(in_ready), 8'h0);
    tick();
    chk_out("bound.drain", 1'b0, 8'h55, 2'd1);
    tick();
    chk_out("bound.idle", 1'b0, 8'h55, 2'd1);

    // Reset mid-beat discards the held beat immediately.
    sel = 2'd2;
    in_valid = 4'hF;
    tick();
    chk_out("mid.load", 1'b1, 8'h3C, 2'd2);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("mid.reset", 1'b0, 8'h00, 2'd0);
    chk("mid.reset.in_ready", 8'(in_ready), 8'h0);
    in_valid = 4'h0;
    tick();
    rst_n = 1'b1;
    tick();
    chk_out("mid.idle", 1'b0, 8'h00, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_n_stream_arb.md
Name: mux_n_stream_arb

Overview:
- Parametrised N-channel, W-bit successor to the 2:1 8-bit select mux, with valid/ready handshakes on every input and on the output.
- Selects one input beat per cycle by forced select, fixed priority or round-robin, and registers it into a one-entry output stage.
- Sits between multiple producers (e.g. adder/ALU result lanes) and a single consumer.

Parameters:
- WIDTH, 8, data width per channel
- NCH, 4, number of input channels (>=2)
- SELW, $clog2(NCH), width of channel index fields

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  NCH  per-channel valid
- in_ready  out  NCH  per-channel ready, one-hot or zero
- mode  in  2  00 forced select, 01 fixed priority, 10 round-robin, 11 treated as round-robin
- sel  in  SELW  channel index used in forced mode
- out_data  out  WIDTH  registered selected data
- out_ch  out  SELW  index of the channel out_data came from
- out_valid  out  1  output holds a beat
- out_ready  in  1  consumer accepts beat

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: out_valid=0, out_data=0, out_ch=0, rr_ptr=0; in_ready is all-zero while rst_n=0.
- Output stage states:
  - EMPTY (out_valid=0) and FULL (out_valid=1).
  - load_en = !out_valid | out_ready.
- Grant (combinational, computed every cycle):
  - mode 00: grant sel if in_valid[sel] and sel<NCH; otherwise no grant. sel>=NCH never grants.
  - mode 01: lowest-index valid channel.
  - mode 10/11: first valid channel searching upward from rr_ptr, wrapping NCH-1 -> 0.
- Handshakes:
  - in_ready[g] = load_en & grant_valid for the granted g; all other bits 0.
  - in_ready never depends on in_valid of a non-granted channel.
- Transfer: on in_valid[g] & in_ready[g] at a rising edge, out_data<=data[g], out_ch<=g, out_valid<=1. Latency is one cycle from transfer to out_valid.
- Drain:
  - If out_valid & out_ready and no grant, out_valid<=0 and out_data/out_ch hold their last values.
  - Simultaneous drain and load gives back-to-back beats: full throughput, one beat per cycle.
- Backpressure: while out_valid & !out_ready, out_data/out_ch/out_valid stay stable and in_ready=0.
- RR pointer:
  - Updates only on a transfer in mode 10/11: rr_ptr <= (g==NCH-1) ? 0 : g+1.
  - Unchanged in modes 00/01 and on cycles with no transfer.
- Mode/sel changes: take effect the same cycle for grant computation; never alter a beat already held in the output register.
- Reset mid-operation: the held beat is discarded immediately (out_valid falls asynchronously); no input handshake completes during reset.
- No data width arithmetic; out_ch is zero-extended index within SELW.

Decomposition:
- Shared package mux_arb_pkg:
  - Mode encodings MODE_FORCE=2'b00, MODE_FIXED=2'b01, MODE_RR=2'b10.
  - Helper function for a wrapped priority search.
- Sub-module rr_arbiter (NCH, SELW):
  - Holds rr_ptr and produces grant_valid/grant_idx from in_valid, mode, sel.
  - Takes an "advance" strobe from the top level.
- The top level holds the output register and the handshake logic.

Test Plan:
- Reset: assert rst_n=0 mid-beat with out_valid=1 -> out_valid=0, out_data=8'h00, out_ch=0, in_ready=4'b0000 immediately; release -> idle.
- Forced mode, NCH=4, W=8:
  - data {8'hA5,8'h3C,8'h55,8'h01}, all valid, out_ready=1, mode=00, sel=2 -> in_ready=4'b0100; next cycle out_data=8'h3C, out_ch=2.
  - sel toggled 0/1/0 -> out_data 8'h01, 8'h55, 8'h01 on consecutive cycles.
- Fixed priority: in_valid=4'b1010, mode=01 -> channel 1 granted every cycle; channel 3 starves; out_ch=1 repeatedly.
- Round-robin: all valid, mode=10, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles. Then in_valid=4'b1001 from ptr=1 -> grants 3 then 0.
- Backpressure: out_valid=1 with out_ready=0 for 3 cycles -> out_data stable, in_ready=0, rr_ptr unchanged. out_ready=1 -> drain and new load in the same cycle, no bubble.
- Boundary: mode=00, sel=3 with in_valid[3]=0, or NCH=3 with sel=3 -> no grant, in_ready=0; out_valid falls after drain.
